// File: rtl/match_controller_pkg.sv
// Shared definitions for the Pong match sequencer: screen states, input codes,
// winner codes, default timing parameters and a saturating score helper.
package match_controller_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SERVE,
    ST_PLAY,
    ST_POINT,
    ST_PAUSE,
    ST_OVER
  } state_e;

  localparam logic [1:0] GOAL_NONE = 2'b00;
  localparam logic [1:0] GOAL_P1   = 2'b01;
  localparam logic [1:0] GOAL_P2   = 2'b10;
  localparam logic [1:0] GOAL_BOTH = 2'b11;

  localparam logic [1:0] PSEL_RESUME     = 2'd0;
  localparam logic [1:0] PSEL_RESTART    = 2'd1;
  localparam logic [1:0] PSEL_QUIT       = 2'd2;
  localparam logic [1:0] PSEL_RESUME_ALT = 2'd3;

  localparam logic [1:0] WINNER_NONE = 2'b00;
  localparam logic [1:0] WINNER_P1   = 2'b01;
  localparam logic [1:0] WINNER_P2   = 2'b10;

  localparam int CNT_W = 8;

  localparam int DEF_WIN_SCORE   = 9;
  localparam int DEF_SERVE_DELAY = 60;
  localparam int DEF_POINT_HOLD  = 90;
  localparam int DEF_OVER_HOLD   = 180;

  function automatic logic [3:0] sat_inc(input logic [3:0] s, input logic [3:0] lim);
    return (s >= lim) ? lim : s + 4'd1;
  endfunction

endpackage

// File: rtl/match_controller_if.sv
// Match controller signal bundle: tick/button inputs toward the controller,
// screen enables, scores and game gating back toward the game blocks.
interface match_controller_if;
  import match_controller_pkg::*;

  logic       frame_tick;
  logic       enter;
  logic       pause_req;
  logic [1:0] pause_selection;
  logic [1:0] goal;

  logic       game_step;
  logic       ball_reset;
  logic       serve_dir;
  logic       enable_start;
  logic       enable_game;
  logic       enable_pause;
  logic       enable_over;
  logic [3:0] score_one;
  logic [3:0] score_two;
  logic [1:0] winner;
  state_e     state_dbg;

  // All inputs are single-cycle pulses or levels sampled on the rising clock edge;
  // there is no backpressure, so no valid/ready pairing exists on this bundle.
  modport master (
    output frame_tick, enter, pause_req, pause_selection, goal,
    input  game_step, ball_reset, serve_dir, enable_start, enable_game,
           enable_pause, enable_over, score_one, score_two, winner, state_dbg
  );

  modport slave (
    input  frame_tick, enter, pause_req, pause_selection, goal,
    output game_step, ball_reset, serve_dir, enable_start, enable_game,
           enable_pause, enable_over, score_one, score_two, winner, state_dbg
  );
endinterface

// File: rtl/match_controller_frame_delay.sv
// Frame_tick counter with clear, hold (run low) and terminal-count compare.
// done fires on the tick that brings the count to limit; reached is a level.
module match_controller_frame_delay
  import match_controller_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             run,
  input  logic             frame_tick,
  input  logic [CNT_W-1:0] limit,
  output logic             done,
  output logic             reached
);

  logic [CNT_W-1:0] count;
  logic [CNT_W:0]   count_inc;

  assign count_inc = {1'b0, count} + {{CNT_W{1'b0}}, 1'b1};
  assign done      = run & frame_tick & (count_inc == {1'b0, limit});
  assign reached   = (count >= limit);

  // Saturates at limit so a long stay in OVER never wraps back below it.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      count <= '0;
    end else if (run && frame_tick && (count != limit)) begin
      count <= count_inc[CNT_W-1:0];
    end
  end

endmodule

// File: rtl/match_controller.sv
// Pong match sequencer: screen mode FSM, game tick gating, serve requests,
// score keeping and winner detection.
module match_controller
  import match_controller_pkg::*;
#(
  parameter int WIN_SCORE   = DEF_WIN_SCORE,
  parameter int SERVE_DELAY = DEF_SERVE_DELAY,
  parameter int POINT_HOLD  = DEF_POINT_HOLD,
  parameter int OVER_HOLD   = DEF_OVER_HOLD
) (
  input  logic               clk,
  input  logic               reset,
  match_controller_if.slave  bus
);

  localparam logic [3:0]       WIN       = 4'(WIN_SCORE);
  localparam logic [CNT_W-1:0] SERVE_LIM = CNT_W'(SERVE_DELAY);
  localparam logic [CNT_W-1:0] POINT_LIM = CNT_W'(POINT_HOLD);
  localparam logic [CNT_W-1:0] OVER_LIM  = CNT_W'(OVER_HOLD);

  state_e           state, state_next, ret_state;
  logic             score_clear, goal_one, goal_two, resume;
  logic             cnt_clear, cnt_run, cnt_done, cnt_reached;
  logic [CNT_W-1:0] cnt_limit;
  logic [3:0]       s1_inc, s2_inc;

  assign s1_inc = sat_inc(bus.score_one, WIN);
  assign s2_inc = sat_inc(bus.score_two, WIN);

  assign bus.game_step = bus.frame_tick & (state == ST_PLAY);
  assign bus.state_dbg = state;

  // Leaving for PAUSE and resuming from it keep the count; every other entry restarts it.
  assign cnt_clear = (state_next != state) && (state_next != ST_PAUSE) && !resume;
  assign cnt_run   = (state == ST_SERVE) || (state == ST_POINT) || (state == ST_OVER);

  always_comb begin
    cnt_limit = OVER_LIM;
    case (state)
      ST_SERVE: cnt_limit = SERVE_LIM;
      ST_POINT: cnt_limit = POINT_LIM;
      default:  cnt_limit = OVER_LIM;
    endcase
  end

  match_controller_frame_delay u_frame_delay (
    .clk        (clk),
    .reset      (reset),
    .clear      (cnt_clear),
    .run        (cnt_run),
    .frame_tick (bus.frame_tick),
    .limit      (cnt_limit),
    .done       (cnt_done),
    .reached    (cnt_reached)
  );

  always_comb begin
    state_next  = state;
    score_clear = 1'b0;
    goal_one    = 1'b0;
    goal_two    = 1'b0;
    resume      = 1'b0;
    case (state)
      ST_IDLE: begin
        if (bus.enter) begin
          state_next  = ST_SERVE;
          score_clear = 1'b1;
        end
      end
      ST_SERVE: begin
        if (cnt_done)           state_next = ST_PLAY;
        else if (bus.pause_req) state_next = ST_PAUSE;
      end
      ST_PLAY: begin
        // A goal outranks a simultaneous pause request.
        case (bus.goal)
          GOAL_P1: begin
            goal_one   = 1'b1;
            state_next = (s1_inc == WIN) ? ST_OVER : ST_POINT;
          end
          GOAL_P2: begin
            goal_two   = 1'b1;
            state_next = (s2_inc == WIN) ? ST_OVER : ST_POINT;
          end
          GOAL_NONE, GOAL_BOTH: begin
            if (bus.pause_req) state_next = ST_PAUSE;
          end
          default: state_next = state;
        endcase
      end
      ST_POINT: begin
        if (cnt_done) state_next = ST_SERVE;
      end
      ST_PAUSE: begin
        if (bus.enter) begin
          case (bus.pause_selection)
            PSEL_RESUME, PSEL_RESUME_ALT: begin
              state_next = ret_state;
              resume     = 1'b1;
            end
            PSEL_RESTART: begin
              state_next  = ST_SERVE;
              score_clear = 1'b1;
            end
            PSEL_QUIT: begin
              state_next  = ST_IDLE;
              score_clear = 1'b1;
            end
            default: state_next = state;
          endcase
        end
      end
      ST_OVER: begin
        if (bus.enter && cnt_reached) begin
          state_next  = ST_IDLE;
          score_clear = 1'b1;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state            <= ST_IDLE;
      ret_state        <= ST_SERVE;
      bus.ball_reset   <= 1'b0;
      bus.enable_start <= 1'b1;
      bus.enable_game  <= 1'b0;
      bus.enable_pause <= 1'b0;
      bus.enable_over  <= 1'b0;
    end else begin
      state <= state_next;
      if ((state_next == ST_PAUSE) && (state != ST_PAUSE)) ret_state <= state;
      bus.ball_reset   <= (state_next == ST_SERVE) && (state != ST_SERVE);
      bus.enable_start <= (state_next == ST_IDLE);
      bus.enable_game  <= (state_next == ST_SERVE) || (state_next == ST_PLAY) ||
                          (state_next == ST_POINT);
      bus.enable_pause <= (state_next == ST_PAUSE);
      bus.enable_over  <= (state_next == ST_OVER);
    end
  end

  always_ff @(posedge clk) begin
    if (reset || score_clear) begin
      bus.score_one <= 4'd0;
      bus.score_two <= 4'd0;
      bus.winner    <= WINNER_NONE;
      bus.serve_dir <= 1'b0;
    end else if (goal_one) begin
      bus.score_one <= s1_inc;
      bus.serve_dir <= 1'b1;
      if (s1_inc == WIN) bus.winner <= WINNER_P1;
    end else if (goal_two) begin
      bus.score_two <= s2_inc;
      bus.serve_dir <= 1'b0;
      if (s2_inc == WIN) bus.winner <= WINNER_P2;
    end
  end

endmodule
